softmax_sum_log2: RTL and testbench
===================================

// Module: softmax_sum_log2
// PURPOSE
//  Downstream of the RU in its stage-1 pass. Accumulates one frame of N_ELEM pow2 terms (RU out_1, Q8.8).
//  Then produces the Mitchell-approximated log2 of the frame sum in Q8.8.
//  The result is the log2_sum operand that feeds RU in_0 during the stage-2 pass: (log2_sum - y_i).
// PARAMETERS
//  N_ELEM  8   elements per softmax frame (>=2)
//  ACC_W   16+$clog2(N_ELEM) (localparam, derived)  accumulator width, unsigned Q(ACC_W-8).8
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  en         in   1   global stall; when low all state, counters and outputs hold, valid_in ignored
//  valid_in   in   1   in_data beat qualifier (one beat per cycle max)
//  in_data    in   16  signed Q8.8 pow2 term from RU out_1
//  ready      out  1   high in IDLE/ACCUM; beats with ready=0 are dropped
//  log2_sum   out  16  signed Q8.8 log2(sum); holds until next result
//  valid_out  out  1   one-cycle pulse when log2_sum updates
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, cnt=0, log2_sum=16'h0000, valid_out=0, ready=1.
//  Beat accepted when en & valid_in & ready. Negative in_data is clamped to 0 before accumulation.
//  FSM (advances only when en=1):
//   IDLE  : accepted beat -> acc<=in, cnt<=1, go ACCUM
//   ACCUM : accepted beat -> acc<=acc+in, cnt<=cnt+1; on the beat making cnt==N_ELEM go LOG
//   LOG   : log2_sum<=f(acc), go DONE; ready=0
//   DONE  : valid_out=1 for this cycle only, acc<=0, cnt<=0, go IDLE; ready=0
//  Latency: result visible with valid_out exactly 2 en-cycles after the edge accepting the last beat.
//  f(acc): p = index of the leading one of acc (bit 8 == 1.0)
//   int  = p-8, signed 8-bit, so it is negative when sum<1.0
//   frac = acc bits [p-1:p-8], zero-filled below bit 0
//   result = {int, frac}
//  acc==0 -> result = 16'h8000 (log2 of zero saturates to the most negative value).
//  acc cannot overflow: the ACC_W sizing covers N_ELEM x 16'h7FFF.
//  Stall (en=0) mid-frame: nothing changes; the frame resumes when en returns.
//  rst mid-frame: partial sum discarded; log2_sum returns to 0; no valid_out.
//  valid_in while in LOG/DONE: dropped, no effect on the next frame.
// CONFIGURATION
//  SUMLOG_ROUND_EN defined: frac rounded half-up using acc bit p-9 (0 if p<9).
//   A rounding carry propagates into int (e.g. 1.FF+ -> 2.00).
//  Not defined: frac truncated. No other behavioural difference.
// STRUCTURE
//  Shared header softmax_q88_defs.vh: Q_FRAC=8, Q_ONE=16'h0100, LOG2_ZERO=16'h8000,
//   and the FSM state encodings IDLE/ACCUM/LOG/DONE.
//  Sub-module log2_approx_q88: combinational leading-one detect plus Mitchell mapping.
//   Parameterised on ACC_W, with the optional rounding. Top holds FSM, counter, accumulator, output reg.
// TESTING
//  8 beats of 16'h0100 -> sum 8.0 -> log2_sum=16'h0300, valid_out one pulse 2 cycles after last beat.
//  8 beats of 16'h0080 -> sum 4.0 -> 16'h0200.
//  Beats summing to 16'h0300 (3.0) -> 16'h0180.
//   Same value with SUMLOG_ROUND_EN; vary the beats so acc has bit p-9 set and check +1 LSB.
//  All-zero frame -> 16'h8000.
//  Frame sum 16'h0040 (0.25) -> 16'hFE00; negative beats (16'hFF00) contribute 0.
//  en dropped for 3 cycles mid-frame, then valid_in during LOG/DONE (dropped), then rst after 4 beats:
//   result is unchanged by the stall and stray beats; after rst there is no valid_out and log2_sum=0.
//   The next full frame computes correctly.

Source files
------------

// File: rtl/softmax_sum_log2_pkg.sv
// softmax_sum_log2_pkg: shared Q8.8 constants and FSM state encoding for the
// softmax stage-1 sum/log2 block.
//   Q_FRAC    : fractional bits of the Q8.8 format
//   Q_ONE     : 1.0 in Q8.8
//   LOG2_ZERO : result reported for log2(0), the most negative Q8.8 value
//   state_e   : frame FSM states
package softmax_sum_log2_pkg;

    localparam int unsigned Q_FRAC    = 8;
    localparam logic [15:0] Q_ONE     = 16'h0100;
    localparam logic [15:0] LOG2_ZERO = 16'h8000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StLog   = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/softmax_sum_log2_approx.sv
// softmax_sum_log2_approx: combinational Mitchell approximation of log2 for an
// unsigned Q(ACC_W-8).8 accumulator, producing a signed Q8.8 result.
//   acc    in  ACC_W  unsigned fixed-point sum (bit 8 == 1.0)
//   result out 16     {int, frac}; int = leading-one index - 8, frac = the 8 bits
//                     below the leading one; acc == 0 gives LOG2_ZERO
// Build option: SUMLOG_ROUND_EN rounds frac half-up on the next lower bit,
// letting the carry ripple into int. Without it frac is truncated.
module softmax_sum_log2_approx
    import softmax_sum_log2_pkg::*;
#(
    parameter int unsigned ACC_W = 19
) (
    input  logic [ACC_W-1:0] acc,
    output logic [15:0]      result
);

    logic [7:0]        lead;
    logic [7:0]        int_part;
    logic [Q_FRAC-1:0] frac;
    logic [15:0]       mapped;

    // Highest set bit wins since later iterations overwrite earlier ones.
    always_comb begin
        lead = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (acc[i]) begin
                lead = 8'(i);
            end
        end
    end

    assign int_part = lead - 8'(Q_FRAC);

`ifdef SUMLOG_ROUND_EN
    localparam int unsigned WIN_W = Q_FRAC + 1;

    // Window holds acc[lead-1 : lead-9]; zero padding supplies bits below bit 0.
    logic [WIN_W-1:0] window;

    assign window = WIN_W'({acc, {WIN_W{1'b0}}} >> lead);
    assign frac   = window[WIN_W-1:1];
    assign mapped = {int_part, frac} + {15'b0, window[0]};
`else
    // Window holds acc[lead-1 : lead-8]; zero padding supplies bits below bit 0.
    assign frac   = Q_FRAC'({acc, {Q_FRAC{1'b0}}} >> lead);
    assign mapped = {int_part, frac};
`endif

    assign result = (acc == '0) ? LOG2_ZERO : mapped;

endmodule

// File: rtl/softmax_sum_log2.sv
// softmax_sum_log2: accumulates one frame of N_ELEM Q8.8 pow2 terms and
// registers the Mitchell log2 of the frame sum (the log2_sum operand for the
// stage-2 pass).
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   en         in   1   global stall; low holds every register
//   valid_in   in   1   in_data qualifier
//   in_data    in   16  signed Q8.8 term; negatives count as zero
//   ready      out  1   high while a frame can take beats (IDLE/ACCUM)
//   log2_sum   out  16  signed Q8.8 log2 of the last frame sum
//   valid_out  out  1   one-cycle pulse when log2_sum updates
// Build option: SUMLOG_ROUND_EN selects rounding in softmax_sum_log2_approx.
module softmax_sum_log2
    import softmax_sum_log2_pkg::*;
#(
    parameter int unsigned N_ELEM = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        valid_in,
    input  logic [15:0] in_data,
    output logic        ready,
    output logic [15:0] log2_sum,
    output logic        valid_out
);

    // Wide enough for N_ELEM x 16'h7FFF without overflow.
    localparam int unsigned ACC_W = 16 + $clog2(N_ELEM);
    localparam int unsigned CNT_W = $clog2(N_ELEM + 1);

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] in_clamped;
    logic [15:0]      log2_result;

    assign in_clamped = in_data[15] ? '0 : {{(ACC_W - 15){1'b0}}, in_data[14:0]};
    assign ready      = (state_q == StIdle) || (state_q == StAccum);

    softmax_sum_log2_approx #(
        .ACC_W (ACC_W)
    ) u_log2 (
        .acc    (acc_q),
        .result (log2_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            log2_sum  <= '0;
            valid_out <= 1'b0;
        end else if (en) begin
            valid_out <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        acc_q   <= in_clamped;
                        cnt_q   <= CNT_W'(1);
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (valid_in) begin
                        acc_q <= acc_q + in_clamped;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(N_ELEM - 1)) begin
                            state_q <= StLog;
                        end
                    end
                end
                StLog: begin
                    log2_sum  <= log2_result;
                    valid_out <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_sum_log2.sv
// Directed bench for softmax_sum_log2 (N_ELEM = 8). Inputs are driven and
// outputs sampled on the falling clock edge. Expected values follow the
// SUMLOG_ROUND_EN build option where rounding changes the result.
module tb_softmax_sum_log2;

    logic        clk;
    logic        rst;
    logic        en;
    logic        valid_in;
    logic [15:0] in_data;
    logic        ready;
    logic [15:0] log2_sum;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    softmax_sum_log2 #(
        .N_ELEM (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .valid_in  (valid_in),
        .in_data   (in_data),
        .ready     (ready),
        .log2_sum  (log2_sum),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Eight back-to-back beats, then the latency/pulse checks.
    task automatic run_frame(input logic [15:0] b [8], input logic [15:0] exp,
                             input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            in_data  = b[i];
        end
        @(negedge clk);
        valid_in = 1'b0;
        in_data  = 16'h0000;
        check({tag, " valid_out 1 cycle after"}, {15'b0, valid_out}, 16'h0000);
        check({tag, " ready in LOG"}, {15'b0, ready}, 16'h0000);
        @(negedge clk);
        check({tag, " valid_out 2 cycles after"}, {15'b0, valid_out}, 16'h0001);
        check({tag, " log2_sum"}, log2_sum, exp);
        @(negedge clk);
        check({tag, " valid_out drops"}, {15'b0, valid_out}, 16'h0000);
        check({tag, " ready back"}, {15'b0, ready}, 16'h0001);
        check({tag, " log2_sum held"}, log2_sum, exp);
    endtask

    logic [15:0] b [8];
    logic [15:0] exp_val;

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        valid_in = 1'b0;
        in_data  = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset log2_sum", log2_sum, 16'h0000);
        check("reset valid_out", {15'b0, valid_out}, 16'h0000);
        check("reset ready", {15'b0, ready}, 16'h0001);
        rst = 1'b0;

        // 8 x 1.0 = 8.0 -> 3.0
        for (int i = 0; i < 8; i++) b[i] = 16'h0100;
        run_frame(b, 16'h0300, "sum8");

        // 8 x 0.5 = 4.0 -> 2.0
        for (int i = 0; i < 8; i++) b[i] = 16'h0080;
        run_frame(b, 16'h0200, "sum4");

        // 8 x 0.375 = 3.0 -> 1.5
        for (int i = 0; i < 8; i++) b[i] = 16'h0060;
        run_frame(b, 16'h0180, "sum3");

        // 0x301: bit below frac is set
        for (int i = 0; i < 7; i++) b[i] = 16'h0060;
        b[7] = 16'h0061;
`ifdef SUMLOG_ROUND_EN
        exp_val = 16'h0181;
`else
        exp_val = 16'h0180;
`endif
        run_frame(b, exp_val, "sum3_lsb");

        // 0x3FF: rounding carry ripples into int
        for (int i = 0; i < 7; i++) b[i] = 16'h0080;
        b[7] = 16'h007F;
`ifdef SUMLOG_ROUND_EN
        exp_val = 16'h0200;
`else
        exp_val = 16'h01FF;
`endif
        run_frame(b, exp_val, "sum3ff");

        // All zero -> saturated most negative
        for (int i = 0; i < 8; i++) b[i] = 16'h0000;
        run_frame(b, 16'h8000, "zero");

        // 4 x 0x10 plus 4 negative beats clamped to 0 -> 0.25 -> -2.0
        for (int i = 0; i < 8; i++) b[i] = i[0] ? 16'hFF00 : 16'h0010;
        run_frame(b, 16'hFE00, "neg_clamp");

        // Stall mid-frame, stray beats during LOG/DONE
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            in_data  = 16'h0100;
        end
        @(negedge clk);
        en       = 1'b0;
        in_data  = 16'h7FFF;
        repeat (3) @(negedge clk);
        check("stall ready", {15'b0, ready}, 16'h0001);
        check("stall valid_out", {15'b0, valid_out}, 16'h0000);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'h0100;
            @(negedge clk);
        end
        // Last beat accepted; now in LOG with stray beat presented
        in_data = 16'h7FFF;
        check("stall LOG ready", {15'b0, ready}, 16'h0000);
        check("stall LOG valid_out", {15'b0, valid_out}, 16'h0000);
        @(negedge clk);
        check("stall valid_out", {15'b0, valid_out}, 16'h0001);
        check("stall log2_sum", log2_sum, 16'h0300);
        check("stall DONE ready", {15'b0, ready}, 16'h0000);
        @(negedge clk);
        valid_in = 1'b0;
        in_data  = 16'h0000;
        check("stall pulse ends", {15'b0, valid_out}, 16'h0000);

        // Stray beats must not have started a frame: clean 3.0 frame
        for (int i = 0; i < 8; i++) b[i] = 16'h0060;
        run_frame(b, 16'h0180, "after_stray");

        // Partial frame then reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            in_data  = 16'h0100;
        end
        @(negedge clk);
        valid_in = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst log2_sum", log2_sum, 16'h0000);
        check("rst ready", {15'b0, ready}, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst no valid_out", {15'b0, valid_out}, 16'h0000);
        end

        // Full frame after reset: partial sum must be gone
        for (int i = 0; i < 8; i++) b[i] = 16'h0080;
        run_frame(b, 16'h0200, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
